// File: rtl/pmp_checker_seq.sv
// ============================================================================
// pmp_checker_seq
// ----------------------------------------------------------------------------
// Multi-cycle RISC-V PMP checker sitting between the MMU/LSU and the memory
// port. A request describes a whole access range [paddr, paddr+2^size-1].
// The checker walks the PMP entries ENT_PER_CYC at a time, stops at the first
// group that contains a matching entry (the lowest-indexed match inside that
// group decides) and returns allow/deny on a valid/ready response channel.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holds valid and its payload
// stable until that edge; ready may not depend combinationally on valid.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     request handshake; ready is high only in IDLE
//   req_paddr           start physical address (PADDR_W bits)
//   req_size            log2 of access bytes (0:1B .. 3:8B)
//   req_access          {X,W,R} one-hot
//   req_priv            privilege level (M = 2'b11)
//   csr_pmpcfg          packed pmpcfg bytes, entry 0 in the LSBs
//   csr_pmpaddr         packed pmpaddr registers, PADDR_W-2 bits each
//   csr_update          pulse: a pmpcfg/pmpaddr CSR was written this cycle
//   resp_valid/ready    response handshake; payload held until accepted
//   resp_allowed        1 => access permitted
//   resp_hit            1 => an entry matched fully or partially
//   resp_idx            index of the deciding entry, 0 without a hit
// ============================================================================
module pmp_checker_seq #(
    parameter int PMP_ENTRIES = 16,
    parameter int PADDR_W     = 56,
    parameter int PMP_G       = 0,
    parameter int ENT_PER_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [PADDR_W-1:0]      req_paddr,
    input  logic [1:0]              req_size,
    input  logic [2:0]              req_access,
    input  logic [1:0]              req_priv,
    // With zero implemented entries the CSR buses keep a one-entry width so
    // the port list stays legal; their contents are then ignored.
    input  logic [8*((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)-1:0]           csr_pmpcfg,
    input  logic [(PADDR_W-2)*((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)-1:0] csr_pmpaddr,
    input  logic                    csr_update,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_allowed,
    output logic                    resp_hit,
    output logic [5:0]              resp_idx
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int AW       = PADDR_W - 2;        // pmpaddr width
    localparam int W1       = PADDR_W + 1;        // range bounds incl. carry
    localparam int NGRP     = (PMP_ENTRIES + ENT_PER_CYC - 1) / ENT_PER_CYC;
    localparam int NG1      = (NGRP > 0) ? NGRP : 1;
    localparam int NPAD     = NG1 * ENT_PER_CYC;  // entries rounded up to groups
    localparam int GW       = (NG1 > 1) ? $clog2(NG1) : 1;
    localparam int IW       = (NPAD > 1) ? $clog2(NPAD) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NG1 - 1);

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;
    localparam logic [1:0] PRIV_M  = 2'b11;

    function automatic logic [AW-1:0] low_ones(input int n);
        logic [AW-1:0] m;
        m = '0;
        for (int b = 0; b < AW; b++) begin
            if (b < n) m[b] = 1'b1;
        end
        return m;
    endfunction

    // Granularity: NAPOT reads pmpaddr[G-2:0] as ones, OFF/TOR read
    // pmpaddr[G-1:0] as zeros. Both masks are empty for G=0.
    localparam logic [AW-1:0] NAPOT_SET = low_ones(PMP_G - 1);
    localparam logic [AW-1:0] TOR_CLR   = low_ones(PMP_G);

    // pmpaddr as seen by the matcher, after granularity read-masking.
    function automatic logic [AW-1:0] eff_addr(input logic [1:0] mode,
                                               input logic [AW-1:0] raw);
        logic [AW-1:0] r;
        case (mode)
            A_NAPOT: r = raw | NAPOT_SET;
            A_NA4:   r = raw;
            default: r = raw & ~TOR_CLR;
        endcase
        return r;
    endfunction

    // Is byte address a inside the region described by one entry?
    // top_w/base_w are word addresses (pmpaddr format).
    function automatic logic in_region(input logic [1:0]    mode,
                                       input logic [AW-1:0] top_w,
                                       input logic [AW-1:0] base_w,
                                       input logic [W1-1:0] a);
        logic [W1-1:0] top_b;
        logic [W1-1:0] base_b;
        logic [AW-1:0] m;
        logic          r;
        top_b  = {1'b0, top_w, 2'b00};
        base_b = {1'b0, base_w, 2'b00};
        // Trailing ones plus the first zero bit: the NAPOT "don't care" mask.
        // An all-ones pmpaddr wraps to an all-ones mask, i.e. the whole space.
        m      = top_w ^ (top_w + 1'b1);
        r      = 1'b0;
        case (mode)
            // base >= top yields an empty interval, so no extra check needed.
            A_TOR:   r = (a >= base_b) && (a < top_b);
            A_NA4:   r = (PMP_G == 0) && (a[W1-1:2] == {1'b0, top_w});
            A_NAPOT: r = !a[PADDR_W] &&
                         ((a[PADDR_W-1:2] & ~m) == (top_w & ~m));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Unpack CSRs into per-entry arrays; pad the last group with OFF entries.
    // ------------------------------------------------------------------------
    logic [7:0]    cfg_arr  [NPAD];
    logic [AW-1:0] raw_arr  [NPAD];
    logic [AW-1:0] eff_arr  [NPAD];
    logic [AW-1:0] base_arr [NPAD];

    for (genvar j = 0; j < NPAD; j++) begin : g_ent
        if (j < PMP_ENTRIES) begin : g_impl
            logic [1:0] unused_rsvd;
            assign cfg_arr[j]  = csr_pmpcfg[j*8 +: 8];
            assign raw_arr[j]  = csr_pmpaddr[j*AW +: AW];
            assign unused_rsvd = cfg_arr[j][6:5];
        end else begin : g_pad
            assign cfg_arr[j] = '0;
            assign raw_arr[j] = '0;
        end
        assign eff_arr[j] = eff_addr(cfg_arr[j][4:3], raw_arr[j]);
        // TOR lower bound comes from the previous entry, 0 for entry 0.
        if (j == 0) begin : g_base0
            assign base_arr[j] = '0;
        end else begin : g_basen
            assign base_arr[j] = eff_arr[j-1];
        end
    end

    // ------------------------------------------------------------------------
    // Latched request and FSM state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [GW-1:0]       grp;
    logic [PADDR_W-1:0]  lat_lo;
    logic [W1-1:0]       lat_hi;
    logic [2:0]          lat_access;
    logic [1:0]          lat_priv;

    logic [2:0]          size_m1;
    always_comb begin
        size_m1 = 3'd0;
        case (req_size)
            2'd0:    size_m1 = 3'd0;
            2'd1:    size_m1 = 3'd1;
            2'd2:    size_m1 = 3'd3;
            default: size_m1 = 3'd7;
        endcase
    end

    // ------------------------------------------------------------------------
    // One group of lanes evaluated per SCAN cycle against the live CSRs.
    // ------------------------------------------------------------------------
    logic [IW-1:0] grp_base;
    logic [IW-1:0] lane_idx     [ENT_PER_CYC];
    logic          lane_hit     [ENT_PER_CYC];
    logic          lane_allowed [ENT_PER_CYC];

    assign grp_base = IW'(grp) * IW'(ENT_PER_CYC);

    for (genvar k = 0; k < ENT_PER_CYC; k++) begin : g_lane
        logic [7:0] cfg;
        logic       lo_in;
        logic       hi_in;
        logic       perm;
        assign lane_idx[k] = grp_base + IW'(k);
        assign cfg         = cfg_arr[lane_idx[k]];
        assign lo_in       = in_region(cfg[4:3], eff_arr[lane_idx[k]],
                                       base_arr[lane_idx[k]], {1'b0, lat_lo});
        assign hi_in       = in_region(cfg[4:3], eff_arr[lane_idx[k]],
                                       base_arr[lane_idx[k]], lat_hi);
        // M-mode bypasses R/W/X unless the entry is locked.
        assign perm        = (lat_priv != PRIV_M || cfg[7]) ?
                             |(cfg[2:0] & lat_access) : 1'b1;
        // A partial match (only one endpoint inside) is a hit but a deny.
        assign lane_hit[k]     = lo_in | hi_in;
        assign lane_allowed[k] = lo_in & hi_in & perm;
    end

    logic          found;
    logic          found_allowed;
    logic [IW-1:0] found_idx;

    // Walk downwards so the lowest-indexed hit is the last one written.
    always_comb begin
        found         = 1'b0;
        found_allowed = 1'b0;
        found_idx     = '0;
        for (int k = ENT_PER_CYC - 1; k >= 0; k--) begin
            if (lane_hit[k]) begin
                found         = 1'b1;
                found_allowed = lane_allowed[k];
                found_idx     = lane_idx[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grp          <= '0;
            lat_lo       <= '0;
            lat_hi       <= '0;
            lat_access   <= '0;
            lat_priv     <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_allowed <= 1'b0;
            resp_hit     <= 1'b0;
            resp_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        lat_lo     <= req_paddr;
                        lat_hi     <= {1'b0, req_paddr} + W1'(size_m1);
                        lat_access <= req_access;
                        lat_priv   <= req_priv;
                        grp        <= '0;
                        if (PMP_ENTRIES == 0) begin
                            state        <= RESP;
                            resp_valid   <= 1'b1;
                            resp_allowed <= 1'b1;
                            resp_hit     <= 1'b0;
                            resp_idx     <= '0;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                SCAN: begin
                    if (lat_hi[PADDR_W]) begin
                        // Range wraps past the top of the address space.
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_allowed <= 1'b0;
                        resp_hit     <= 1'b0;
                        resp_idx     <= '0;
                    end else if (csr_update) begin
                        // CSRs changed under us: rescan from entry 0.
                        grp <= '0;
                    end else if (found) begin
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_allowed <= found_allowed;
                        resp_hit     <= 1'b1;
                        resp_idx     <= 6'(found_idx);
                    end else if (grp == LAST_GRP) begin
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_allowed <= (lat_priv == PRIV_M);
                        resp_hit     <= 1'b0;
                        resp_idx     <= '0;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        state        <= IDLE;
                        req_ready    <= 1'b1;
                        resp_valid   <= 1'b0;
                        resp_allowed <= 1'b0;
                        resp_hit     <= 1'b0;
                        resp_idx     <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_checker_seq.sv
// ============================================================================
// tb_pmp_checker_seq
// ----------------------------------------------------------------------------
// Directed bench for pmp_checker_seq with default parameters
// (16 entries, 56-bit paddr, G=0, 4 entries per cycle => 4 groups).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// at the same point.
// ============================================================================
module tb_pmp_checker_seq;

    localparam int NE = 16;
    localparam int PW = 56;
    localparam int AW = PW - 2;

    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;
    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_M = 2'b11;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [PW-1:0]     req_paddr;
    logic [1:0]        req_size;
    logic [2:0]        req_access;
    logic [1:0]        req_priv;
    logic [8*NE-1:0]   csr_pmpcfg;
    logic [AW*NE-1:0]  csr_pmpaddr;
    logic              csr_update;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_allowed;
    logic              resp_hit;
    logic [5:0]        resp_idx;

    logic [7:0]        cfg  [NE];
    logic [AW-1:0]     addr [NE];

    int checks;
    int errors;
    int lat;

    pmp_checker_seq #(
        .PMP_ENTRIES (NE),
        .PADDR_W     (PW),
        .PMP_G       (0),
        .ENT_PER_CYC (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_paddr    (req_paddr),
        .req_size     (req_size),
        .req_access   (req_access),
        .req_priv     (req_priv),
        .csr_pmpcfg   (csr_pmpcfg),
        .csr_pmpaddr  (csr_pmpaddr),
        .csr_update   (csr_update),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_allowed (resp_allowed),
        .resp_hit     (resp_hit),
        .resp_idx     (resp_idx)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- CSR packing ----------------
    always_comb begin
        csr_pmpcfg  = '0;
        csr_pmpaddr = '0;
        for (int i = 0; i < NE; i++) begin
            csr_pmpcfg[i*8 +: 8]   = cfg[i];
            csr_pmpaddr[i*AW +: AW] = addr[i];
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_csr();
        for (int i = 0; i < NE; i++) begin
            cfg[i]  = 8'h00;
            addr[i] = '0;
        end
    endtask

    // Wait for req_ready, present one request for one accepting edge.
    task automatic send(input logic [PW-1:0] pa, input logic [1:0] sz,
                        input logic [2:0] acc, input logic [1:0] pv);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        req_paddr  = pa;
        req_size   = sz;
        req_access = acc;
        req_priv   = pv;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    // Count cycles from accept until resp_valid (bounded).
    task automatic wait_resp(input int start, output int l);
        l = start;
        while (!resp_valid && l < start + 60) begin
            @(posedge clk); #1;
            l++;
        end
        chk("resp_valid_wait", resp_valid, 1'b1);
    endtask

    task automatic expect_resp(input string name, input int l, input int el,
                               input logic al, input logic ht,
                               input logic [5:0] ix);
        chk({name, ".latency"}, 64'(l), 64'(el));
        chk({name, ".allowed"}, resp_allowed, al);
        chk({name, ".hit"},     resp_hit, ht);
        chk({name, ".idx"},     resp_idx, ix);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_drop", resp_valid, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_paddr  = '0;
        req_size   = '0;
        req_access = '0;
        req_priv   = '0;
        csr_update = 1'b0;
        resp_ready = 1'b0;
        clear_csr();

        // Reset values
        #12;
        chk("rst.req_ready",    req_ready, 1'b0);
        chk("rst.resp_valid",   resp_valid, 1'b0);
        chk("rst.resp_allowed", resp_allowed, 1'b0);
        chk("rst.resp_hit",     resp_hit, 1'b0);
        chk("rst.resp_idx",     resp_idx, 6'd0);
        rst_n = 1'b1;

        // 1. No entries: U denied, M allowed, full 4-group scan
        send(56'h1000, 2'd0, ACC_R, PRV_U);
        wait_resp(0, lat);
        expect_resp("t1_u", lat, 4, 1'b0, 1'b0, 6'd0);
        finish_resp();
        send(56'h1000, 2'd0, ACC_R, PRV_M);
        wait_resp(0, lat);
        expect_resp("t1_m", lat, 4, 1'b1, 1'b0, 6'd0);
        finish_resp();

        // 2. Entry5 NAPOT 8KB @0, R only; U write denied in group 1
        cfg[5]  = 8'h19;
        addr[5] = 54'h3FF;
        send(56'h100, 2'd3, ACC_W, PRV_U);
        wait_resp(0, lat);
        expect_resp("t2_napot", lat, 2, 1'b0, 1'b1, 6'd5);
        finish_resp();

        // 3. Entry0 TOR [0,0x1000) RWX; straddling read is a partial match
        clear_csr();
        cfg[0]  = 8'h0F;
        addr[0] = 54'h400;
        send(56'hFFC, 2'd3, ACC_R, PRV_U);
        wait_resp(0, lat);
        expect_resp("t3_partial", lat, 1, 1'b0, 1'b1, 6'd0);
        finish_resp();
        send(56'hFF8, 2'd3, ACC_R, PRV_U);
        wait_resp(0, lat);
        expect_resp("t3_full", lat, 1, 1'b1, 1'b1, 6'd0);
        finish_resp();

        // 4. Entry2 NA4 @0x2000 X only: locked binds M, unlocked does not
        clear_csr();
        cfg[2]  = 8'h94;
        addr[2] = 54'h800;
        send(56'h2000, 2'd2, ACC_R, PRV_M);
        wait_resp(0, lat);
        expect_resp("t4_locked", lat, 1, 1'b0, 1'b1, 6'd2);
        finish_resp();
        cfg[2]  = 8'h14;
        send(56'h2000, 2'd2, ACC_R, PRV_M);
        wait_resp(0, lat);
        expect_resp("t4_unlocked", lat, 1, 1'b1, 1'b1, 6'd2);
        finish_resp();

        // Range wrapping past the top of the address space: immediate deny
        send(56'hFF_FFFF_FFFF_FFFC, 2'd3, ACC_R, PRV_M);
        wait_resp(0, lat);
        expect_resp("ovf", lat, 1, 1'b0, 1'b0, 6'd0);
        finish_resp();

        // 5. csr_update in the 2nd SCAN cycle restarts the scan with new CSRs
        clear_csr();
        cfg[5]  = 8'h19;
        addr[5] = 54'h3FF;
        send(56'h100, 2'd2, ACC_R, PRV_U);
        @(posedge clk); #1;          // now in the 2nd SCAN cycle
        cfg[5]     = 8'h00;
        cfg[9]     = 8'h1F;
        addr[9]    = 54'h3FF;
        csr_update = 1'b1;
        @(posedge clk); #1;
        csr_update = 1'b0;
        wait_resp(2, lat);
        expect_resp("t5_restart", lat, 5, 1'b1, 1'b1, 6'd9);
        finish_resp();

        // 6a. Back-pressure: response held stable, no new request accepted
        send(56'h100, 2'd2, ACC_R, PRV_U);
        wait_resp(0, lat);
        expect_resp("t6_hold", lat, 3, 1'b1, 1'b1, 6'd9);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("t6.resp_valid", resp_valid, 1'b1);
            chk("t6.allowed",    resp_allowed, 1'b1);
            chk("t6.idx",        resp_idx, 6'd9);
            chk("t6.req_ready",  req_ready, 1'b0);
        end
        finish_resp();

        // 6b. Asynchronous reset mid-SCAN drops the request
        send(56'h100, 2'd2, ACC_R, PRV_U);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6r.resp_valid", resp_valid, 1'b0);
        chk("t6r.req_ready",  req_ready, 1'b0);
        chk("t6r.resp_hit",   resp_hit, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("t6r.no_resp", resp_valid, 1'b0);
        end
        chk("t6r.ready_back", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
